// File: rtl/ysyx_22041211_pc_seq_pkg.sv
// Shared types and constants for the fetch-side PC sequencer.
// YSYX_22041211_MISALIGN_TRAP_EN adds the TRAP state.
package ysyx_22041211_pkg;

`ifdef YSYX_22041211_MISALIGN_TRAP_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        ISSUE = 3'd3,
        TRAP  = 3'd4
    } state_e;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        ISSUE = 3'd3
    } state_e;
`endif

    localparam logic [1:0] PC_SEQ  = 2'b00;
    localparam logic [1:0] PC_BR   = 2'b01;
    localparam logic [1:0] PC_JALR = 2'b10;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_22041211_pc_seq_if.sv
// Instruction-memory port: request handshake plus unconditional response strobe.
interface ysyx_22041211_pc_seq_if #(
    parameter int ADDR_W = 32
);
    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_req_addr;
    logic              ifu_rsp_valid;
    logic [31:0]       ifu_rsp_inst;

    modport master (
        output ifu_req_valid,
        output ifu_req_addr,
        input  ifu_req_ready,
        input  ifu_rsp_valid,
        input  ifu_rsp_inst
    );

    modport slave (
        input  ifu_req_valid,
        input  ifu_req_addr,
        output ifu_req_ready,
        output ifu_rsp_valid,
        output ifu_rsp_inst
    );
endinterface

// File: rtl/ysyx_22041211_pc_seq_next_pc.sv
// Combinational next-PC select: sequential, pc-relative, or register-relative (jalr).
module ysyx_22041211_next_pc
    import ysyx_22041211_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [1:0]        pc_src,
    input  logic [ADDR_W-1:0] imm,
    input  logic [ADDR_W-1:0] rs1_val,
    output logic [ADDR_W-1:0] next_pc
);
    logic [ADDR_W-1:0] seq_tgt;
    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] jalr_sum;

    assign seq_tgt  = pc + ADDR_W'(4);
    assign br_tgt   = pc + imm;
    assign jalr_sum = rs1_val + imm;

    // Reserved code 11 falls through to sequential.
    always_comb begin
        next_pc = seq_tgt;
        case (pc_src)
            PC_BR:   next_pc = br_tgt;
            PC_JALR: next_pc = {jalr_sum[ADDR_W-1:1], 1'b0};
            default: next_pc = seq_tgt;
        endcase
    end
endmodule

// File: rtl/ysyx_22041211_pc_seq.sv
// Fetch-side PC sequencer: one outstanding fetch, instruction held for decode until consumed.
// YSYX_22041211_MISALIGN_TRAP_EN: trap on targets with bit 1 set instead of forcing alignment.
module ysyx_22041211_pc_seq
    import ysyx_22041211_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              pc_src,
    input  logic [ADDR_W-1:0]       imm,
    input  logic [ADDR_W-1:0]       rs1_val,
    ysyx_22041211_pc_seq_if.master  ifu,
    output logic                    inst_valid,
    input  logic                    inst_ready,
    output logic [31:0]             inst,
    output logic [ADDR_W-1:0]       pc,
    output logic [63:0]             instret
`ifdef YSYX_22041211_MISALIGN_TRAP_EN
    ,
    output logic                    misalign_err
`endif
);
    state_e            state;
    state_e            state_nxt;
    logic              inst_load;
    logic              retire;
    logic [ADDR_W-1:0] npc_raw;
    logic [ADDR_W-1:0] npc;

    ysyx_22041211_next_pc #(
        .ADDR_W (ADDR_W)
    ) u_next_pc (
        .pc      (pc),
        .pc_src  (pc_src),
        .imm     (imm),
        .rs1_val (rs1_val),
        .next_pc (npc_raw)
    );

`ifdef YSYX_22041211_MISALIGN_TRAP_EN
    assign npc          = npc_raw;
    assign misalign_err = (state == TRAP);
`else
    assign npc = {npc_raw[ADDR_W-1:2], 2'b00};
`endif

    always_comb begin
        state_nxt = state;
        inst_load = 1'b0;
        retire    = 1'b0;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                // A response in the same cycle as the handshake belongs to nothing.
                if (ifu.ifu_req_ready) state_nxt = WAIT;
            end
            WAIT: begin
                if (ifu.ifu_rsp_valid) begin
                    inst_load = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (inst_ready) begin
`ifdef YSYX_22041211_MISALIGN_TRAP_EN
                    if (npc_raw[1]) begin
                        state_nxt = TRAP;
                    end else begin
                        retire    = 1'b1;
                        state_nxt = REQ;
                    end
`else
                    retire    = 1'b1;
                    state_nxt = REQ;
`endif
                end
            end
`ifdef YSYX_22041211_MISALIGN_TRAP_EN
            TRAP: state_nxt = TRAP;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            inst    <= 32'd0;
            instret <= 64'd0;
        end else begin
            state <= state_nxt;
            if (inst_load) inst <= ifu.ifu_rsp_inst;
            if (retire) begin
                pc      <= npc;
                instret <= instret + 64'd1;
            end
        end
    end

    assign ifu.ifu_req_valid = (state == REQ);
    assign ifu.ifu_req_addr  = pc;
    assign inst_valid        = (state == ISSUE);
endmodule

// File: tb/tb_ysyx_22041211_pc_seq.sv
// Directed plus randomized bench for the PC sequencer; expected PCs come from a plain arithmetic model.
module tb_ysyx_22041211_pc_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  pc_src;
    logic [31:0] imm;
    logic [31:0] rs1_val;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [63:0] instret;
`ifdef YSYX_22041211_MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_pc;
    logic [63:0] exp_ret;

    ysyx_22041211_pc_seq_if #(.ADDR_W(32)) ifu ();

    ysyx_22041211_pc_seq #(.ADDR_W(32), .RESET_PC(32'h8000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_src     (pc_src),
        .imm        (imm),
        .rs1_val    (rs1_val),
        .ifu        (ifu),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .pc         (pc),
        .instret    (instret)
`ifdef YSYX_22041211_MISALIGN_TRAP_EN
        ,
        .misalign_err (misalign_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural next-PC rule, independent of how the hardware gets there.
    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [1:0] s,
                                               input logic [31:0] i, input logic [31:0] r);
        logic [31:0] t;
        if (s == 2'd1)      t = p + i;
        else if (s == 2'd2) t = (r + i) & 32'hFFFF_FFFE;
        else                t = p + 32'd4;
`ifndef YSYX_22041211_MISALIGN_TRAP_EN
        t = t & 32'hFFFF_FFFC;
`endif
        return t;
    endfunction

    // One full instruction, starting in REQ; noise injects responses outside WAIT.
    task automatic fetch_one(input int rw, input int ww, input int iw, input logic [1:0] s,
                             input logic [31:0] i, input logic [31:0] r, input logic [31:0] ins,
                             input bit noise);
        for (int k = 0; k < rw; k++) begin
            ifu.ifu_req_ready = 1'b0;
            ifu.ifu_rsp_valid = noise;
            ifu.ifu_rsp_inst  = 32'hDEAD_BEEF;
            chk("req_valid_hold", ifu.ifu_req_valid, 1);
            chk("req_addr_hold", ifu.ifu_req_addr, exp_pc);
            tick();
        end
        chk("req_valid", ifu.ifu_req_valid, 1);
        chk("req_addr", ifu.ifu_req_addr, exp_pc);
        ifu.ifu_req_ready = 1'b1;
        ifu.ifu_rsp_valid = noise;
        ifu.ifu_rsp_inst  = 32'hDEAD_BEEF;
        tick();
        ifu.ifu_req_ready = 1'b0;
        ifu.ifu_rsp_valid = 1'b0;
        for (int k = 0; k < ww; k++) begin
            chk("wait_req_valid", ifu.ifu_req_valid, 0);
            chk("wait_inst_valid", inst_valid, 0);
            tick();
        end
        chk("wait_inst_valid", inst_valid, 0);
        ifu.ifu_rsp_valid = 1'b1;
        ifu.ifu_rsp_inst  = ins;
        tick();
        ifu.ifu_rsp_valid = 1'b0;
        for (int k = 0; k < iw; k++) begin
            inst_ready        = 1'b0;
            pc_src            = ~s;
            imm               = ~i;
            rs1_val           = ~r;
            ifu.ifu_rsp_valid = noise;
            ifu.ifu_rsp_inst  = ~ins;
            chk("issue_inst_valid_hold", inst_valid, 1);
            chk("issue_inst_hold", inst, ins);
            chk("issue_pc_hold", pc, exp_pc);
            chk("issue_instret_hold", instret, exp_ret);
            tick();
        end
        ifu.ifu_rsp_valid = 1'b0;
        chk("issue_inst_valid", inst_valid, 1);
        chk("issue_inst", inst, ins);
        chk("issue_pc", pc, exp_pc);
        pc_src     = s;
        imm        = i;
        rs1_val    = r;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        exp_pc  = model_next(exp_pc, s, i, r);
        exp_ret = exp_ret + 64'd1;
        chk("instret", instret, exp_ret);
        chk("next_req_valid", ifu.ifu_req_valid, 1);
        chk("next_req_addr", ifu.ifu_req_addr, exp_pc);
        chk("next_inst_valid", inst_valid, 0);
    endtask

    initial begin
        pc_src            = 2'b00;
        imm               = 32'd0;
        rs1_val           = 32'd0;
        inst_ready        = 1'b0;
        ifu.ifu_req_ready = 1'b0;
        ifu.ifu_rsp_valid = 1'b0;
        ifu.ifu_rsp_inst  = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_pc", pc, 32'h8000_0000);
        chk("rst_inst", inst, 0);
        chk("rst_instret", instret, 0);
        chk("rst_req_valid", ifu.ifu_req_valid, 0);
        chk("rst_inst_valid", inst_valid, 0);
`ifdef YSYX_22041211_MISALIGN_TRAP_EN
        chk("rst_misalign", misalign_err, 0);
`endif
        rst = 1'b0;
        chk("idle_req_valid", ifu.ifu_req_valid, 0);
        tick();
        exp_pc  = 32'h8000_0000;
        exp_ret = 64'd0;
        chk("first_req_addr", ifu.ifu_req_addr, 32'h8000_0000);

        // Sequential, then steer to 0x8000_0010, branch back, then jalr.
        fetch_one(0, 0, 0, 2'b00, 32'd0, 32'd0, 32'h0000_0013, 1'b0);
        chk("tp_seq_addr", ifu.ifu_req_addr, 32'h8000_0004);
        chk("tp_seq_instret", instret, 1);
        fetch_one(0, 0, 0, 2'b01, 32'h0000_000C, 32'd0, 32'h00C0_006F, 1'b0);
        chk("tp_pc_0x10", ifu.ifu_req_addr, 32'h8000_0010);
        fetch_one(0, 1, 0, 2'b01, 32'hFFFF_FFF0, 32'd0, 32'hFE00_08E3, 1'b0);
        chk("tp_branch_back", ifu.ifu_req_addr, 32'h8000_0000);
        fetch_one(0, 0, 0, 2'b10, 32'h0000_0002, 32'h8000_1003, 32'h0020_8067, 1'b0);
        chk("tp_jalr", ifu.ifu_req_addr, 32'h8000_1004);
        fetch_one(0, 0, 0, 2'b11, 32'h0000_0100, 32'd0, 32'h1111_2222, 1'b0);
        chk("tp_reserved_seq", ifu.ifu_req_addr, 32'h8000_1008);

        // Backpressure on both handshakes with stray responses outside WAIT.
        fetch_one(5, 0, 4, 2'b00, 32'd0, 32'd0, 32'hCAFE_F00D, 1'b1);
        chk("tp_bp_instret", instret, 6);

        for (int n = 0; n < 30; n++) begin
            fetch_one($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      2'($urandom_range(0, 3)), $urandom & 32'hFFFF_FFFC,
                      $urandom & 32'hFFFF_FFFC, $urandom, 1'($urandom_range(0, 1)));
        end

        // Reset during WAIT; the stale response must not be captured.
        ifu.ifu_req_ready = 1'b1;
        tick();
        ifu.ifu_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstwait_req_valid", ifu.ifu_req_valid, 0);
        chk("rstwait_pc", pc, 32'h8000_0000);
        chk("rstwait_instret", instret, 0);
        chk("rstwait_inst", inst, 0);
        rst = 1'b0;
        ifu.ifu_rsp_valid = 1'b1;
        ifu.ifu_rsp_inst  = 32'hBADB_AD00;
        tick();
        chk("stale_req_valid", ifu.ifu_req_valid, 1);
        chk("stale_req_addr", ifu.ifu_req_addr, 32'h8000_0000);
        tick();
        ifu.ifu_rsp_valid = 1'b0;
        chk("stale_inst", inst, 0);
        exp_pc  = 32'h8000_0000;
        exp_ret = 64'd0;
        fetch_one(0, 0, 0, 2'b00, 32'd0, 32'd0, 32'h1234_5678, 1'b0);

        // jalr to 0x8000_0002.
        ifu.ifu_req_ready = 1'b1;
        tick();
        ifu.ifu_req_ready = 1'b0;
        ifu.ifu_rsp_valid = 1'b1;
        ifu.ifu_rsp_inst  = 32'h0020_0067;
        tick();
        ifu.ifu_rsp_valid = 1'b0;
        pc_src     = 2'b10;
        imm        = 32'h0000_0002;
        rs1_val    = 32'h8000_0000;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
`ifdef YSYX_22041211_MISALIGN_TRAP_EN
        chk("trap_misalign", misalign_err, 1);
        chk("trap_pc", pc, exp_pc);
        chk("trap_instret", instret, exp_ret);
        for (int k = 0; k < 4; k++) begin
            chk("trap_no_req", ifu.ifu_req_valid, 0);
            tick();
        end
`else
        chk("misalign_forced_addr", ifu.ifu_req_addr, 32'h8000_0000);
        chk("misalign_req_valid", ifu.ifu_req_valid, 1);
        chk("misalign_instret", instret, exp_ret + 64'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ysyx_22041211_pc_seq.md
# ysyx_22041211_pc_seq

Fetch-side PC sequencer that consumes the branch/jump selector's 2-bit `PCSrc` code.
- Holds the architectural PC and issues instruction-fetch requests to instruction memory through a valid/ready handshake.
- Delivers each fetched instruction to decode and computes the next PC once execute resolves it.
- Sits between the instruction-memory port and the decode/execute stage of the core; exactly one fetch is outstanding at a time.

## Interface
Parameters:
- `ADDR_W`, 32, PC and address width.
- `RESET_PC`, 32'h8000_0000, PC value after reset.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pc_src`  in  2  next-PC select: 00 sequential, 01 branch/jal, 10 jalr, 11 reserved.
- `imm`  in  ADDR_W  sign-extended immediate (offset for codes 01 and 10).
- `rs1_val`  in  ADDR_W  jalr base register value.
- `ifu_req_valid`  out  1  fetch request valid.
- `ifu_req_ready`  in  1  memory accepts request.
- `ifu_req_addr`  out  ADDR_W  fetch address; equals `pc`.
- `ifu_rsp_valid`  in  1  fetch data valid.
- `ifu_rsp_inst`  in  32  fetched instruction.
- `inst_valid`  out  1  instruction presented to decode.
- `inst_ready`  in  1  decode/execute consumes it; `pc_src`, `imm` and `rs1_val` are sampled only when this is high.
- `inst`  out  32  held instruction.
- `pc`  out  ADDR_W  current PC.
- `instret`  out  64  retired-instruction counter.
- `misalign_err`  out  1  misaligned-target trap flag; present only under the macro.

## Operation
States and transitions:
- IDLE: unconditionally goes to REQ on the next cycle.
- REQ: `ifu_req_valid`=1. If `ifu_req_ready`, go to WAIT.
- WAIT: on `ifu_rsp_valid`, latch `ifu_rsp_inst` into `inst` and go to ISSUE.
- ISSUE: `inst_valid`=1. On `inst_ready`, load the next PC, increment `instret`, and go to REQ.
- TRAP: reachable only under the macro. Fetching halts; the block leaves TRAP only by reset.

Next-PC computation, all arithmetic modulo 2^ADDR_W with carry-out discarded:
- Code 00: pc+4.
- Code 01: pc+imm.
- Code 10: (rs1_val+imm) & ~1.
- Code 11: pc+4 (reserved code, treated as sequential).

Boundary conditions:
- `ifu_rsp_valid` is ignored outside WAIT. A response arriving in IDLE, REQ or ISSUE is dropped.
- `ifu_rsp_valid` and `ifu_req_ready` in the same cycle while in REQ: the response is dropped; only the request handshake counts.
- `inst` and `pc` stay stable throughout ISSUE until `inst_ready` is sampled.
- `instret` wraps from 2^64-1 to 0.
- `rst` asserted in any state: all registers take their reset values immediately. An in-flight fetch is abandoned, and its late response is dropped because the block is in IDLE or REQ.

## Timing
Reset values:
- `pc`=RESET_PC, state=IDLE, `inst`=0, `instret`=0.
- `ifu_req_valid`=0, `inst_valid`=0, `misalign_err`=0.

Signal timing:
- `ifu_req_valid`, `ifu_req_addr` and `inst_valid` are decoded from registered state (Moore); there is no combinational path from inputs to them.
- Minimum loop per instruction, with ready and response each arriving in the first cycle of their state:
  - C0: REQ handshake.
  - C1: WAIT, response captured.
  - C2: ISSUE, consumed.
  - C3: REQ at the new PC.
- Minimum throughput is 3 cycles per instruction.
- Wait states stretch REQ, WAIT and ISSUE indefinitely; there is no timeout.

## Configuration
Macro `YSYX_22041211_MISALIGN_TRAP_EN`.
- Defined: a next PC with bit 1 set, after jalr masking, is not loaded.
  - State goes to TRAP and `misalign_err` rises to 1 the cycle after consumption.
  - `pc` holds the faulting instruction's PC.
  - `instret` does not increment for that instruction.
- Undefined: bits [1:0] of the next PC are forced to 00, there is no TRAP state, and the `misalign_err` port is absent.

## Structure
- Shared package `ysyx_22041211_pkg` holds:
  - the state enum (IDLE, REQ, WAIT, ISSUE, TRAP);
  - the `pc_src` encodings PC_SEQ=2'b00, PC_BR=2'b01, PC_JALR=2'b10;
  - the default RESET_PC.
- One combinational sub-module, `ysyx_22041211_next_pc`, computes the next PC from the `pc_src` mux plus the two adders. The sequencer instantiates it.

## Test plan
- Reset release, ready tied 1, response always 1 cycle after request:
  - first `ifu_req_addr`=0x8000_0000;
  - `inst_valid` high 2 cycles after the request;
  - consumed with code 00 gives the next request at 0x8000_0004, and `instret`=1.
- Branch: pc=0x8000_0010, code 01, imm=0xFFFF_FFF0 → next request at 0x8000_0000.
- jalr: rs1_val=0x8000_1003, imm=2, code 10 → 0x8000_1004 after masking bit 0 (bit 1 clear, so legal).
- Backpressure: `ifu_req_ready` low 5 cycles, then `inst_ready` low 4 cycles → address and `inst` stable throughout; `instret` increments exactly once.
- `rst` pulsed during WAIT, then a stale `ifu_rsp_valid` arrives → the stale response is dropped and the fetch restarts at 0x8000_0000.
- With the macro defined: jalr target 0x8000_0002 → `misalign_err`=1, `pc` unchanged, no further requests until reset. Without the macro: the next request goes to 0x8000_0000.
